// File: rtl/pcie_fifo_rd_sched.sv
// Round-robin burst scheduler: drains BURST_LEN-beat packets from one of N_CH
// prefetch FIFOs at a time into a single registered valid/ready output stage.
module pcie_fifo_rd_sched #(
  parameter int N_CH      = 4,
  parameter int DW        = 32,
  parameter int BURST_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [N_CH-1:0]            ch_burst_rdy,
  input  logic [N_CH-1:0]            ch_vld,
  input  logic [N_CH*DW-1:0]         ch_data,
  output logic [N_CH-1:0]            ch_rd_en,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DW-1:0]              m_data,
  output logic                       m_sop,
  output logic                       m_eop,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] m_ch,
  output logic                       busy,
  output logic [15:0]                pkt_cnt
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BC_W = $clog2(BURST_LEN);

  // Handshake: a beat transfers on any cycle where m_valid and m_ready are both
  // high; while m_valid is high and m_ready low every m_* output holds stable.

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   gnt_q, ptr_q;
  logic [BC_W-1:0]   bcnt_q;
  logic [CH_W-1:0]   win, win_nxt;
  logic              found;
  logic              pop;
  logic              last_beat;
  logic [DW-1:0]     sel_data;

  logic              m_valid_q, m_sop_q, m_eop_q;
  logic [DW-1:0]     m_data_q;
  logic [CH_W-1:0]   m_ch_q;
  logic [15:0]       pkt_cnt_q;

  // First eligible channel at or after ptr, wrapping modulo N_CH.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_CH; k++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + k) % N_CH;
      if (!found && en && ch_burst_rdy[idx]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
  end

  assign win_nxt   = (int'(win) == N_CH - 1) ? '0 : win + 1'b1;
  assign sel_data  = ch_data[int'(gnt_q)*DW +: DW];
  assign last_beat = (bcnt_q == BC_W'(BURST_LEN - 1));
  assign pop       = (state_q == S_XFER) && ch_vld[gnt_q] && (!m_valid_q || m_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (found) state_d = S_XFER;
      S_XFER: if (pop && last_beat) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ch_rd_en = '0;
    busy     = (state_q == S_XFER);
    if (pop) ch_rd_en[gnt_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      ptr_q     <= '0;
      bcnt_q    <= '0;
      m_valid_q <= 1'b0;
      m_sop_q   <= 1'b0;
      m_eop_q   <= 1'b0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
      pkt_cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE && found) begin
        gnt_q  <= win;
        ptr_q  <= win_nxt;
        bcnt_q <= '0;
      end
      if (pop) begin
        m_data_q  <= sel_data;
        m_ch_q    <= gnt_q;
        m_sop_q   <= (bcnt_q == '0);
        m_eop_q   <= last_beat;
        m_valid_q <= 1'b1;
        bcnt_q    <= bcnt_q + 1'b1;
        if (last_beat) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_sop   = m_sop_q;
  assign m_eop   = m_eop_q;
  assign m_ch    = m_ch_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_pcie_fifo_rd_sched.sv
// Bench for pcie_fifo_rd_sched: emulated FIFOs with tagged data, randomized
// handshakes, and a packet-level reference model with an expected-beat queue.
module tb_pcie_fifo_rd_sched;

  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int BL   = 16;
  localparam int CH_W = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              en;
  logic [N_CH-1:0]   ch_burst_rdy, ch_vld, ch_rd_en;
  logic [N_CH*DW-1:0] ch_data;
  logic              m_valid, m_ready, m_sop, m_eop, busy;
  logic [DW-1:0]     m_data;
  logic [CH_W-1:0]   m_ch;
  logic [15:0]       pkt_cnt;

  pcie_fifo_rd_sched #(.N_CH(N_CH), .DW(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ch_burst_rdy(ch_burst_rdy), .ch_vld(ch_vld), .ch_data(ch_data),
    .ch_rd_en(ch_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop), .m_ch(m_ch),
    .busy(busy), .pkt_cnt(pkt_cnt)
  );

  // FIFO emulation: each channel presents {channel, sequence number}
  int seq [N_CH];
  always_comb begin
    ch_data = '0;
    for (int i = 0; i < N_CH; i++) ch_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic sop, input logic eop,
                                       input logic [7:0] ch, input logic [31:0] d);
    return {22'd0, sop, eop, ch, d};
  endfunction

  // reference model: packet-level view of the arbiter
  bit md_busy = 0;
  int md_gnt = 0, md_ptr = 0, md_beat = 0, md_pkt = 0;
  bit after_rst = 0;

  // stimulus knobs
  bit               rdy_rand = 0;
  logic [N_CH-1:0]  rdy_fixed = '0;
  int p_vld = 100, p_ready = 100, p_en = 100;
  bit rst_pulse = 0;

  task automatic drive_inputs();
    ch_burst_rdy = rdy_rand ? N_CH'($urandom_range(0, (1 << N_CH) - 1)) : rdy_fixed;
    for (int i = 0; i < N_CH; i++) ch_vld[i] = ($urandom_range(0, 99) < p_vld);
    m_ready = ($urandom_range(0, 99) < p_ready);
    en      = ($urandom_range(0, 99) < p_en);
    rst_n   = !rst_pulse;
    rst_pulse = 0;
  endtask

  task automatic step();
    bit exp_valid, accept, pop;
    logic [N_CH-1:0] exp_rd, fifo_pop;
    @(negedge clk);
    exp_valid = (exp_q.size() != 0);
    chk("m_valid", m_valid, exp_valid);
    if (exp_valid) chk("beat", pack(m_sop, m_eop, 8'(m_ch), m_data), exp_q[0]);
    if (after_rst) begin
      chk("rst_m_data", m_data, 0);
      chk("rst_m_sop", m_sop, 0);
      chk("rst_m_eop", m_eop, 0);
      chk("rst_m_ch", m_ch, 0);
      after_rst = 0;
    end
    chk("busy", busy, md_busy);
    chk("pkt_cnt", pkt_cnt, 16'(md_pkt));
    accept = exp_valid && m_ready;
    pop    = md_busy && ch_vld[md_gnt] && (!exp_valid || m_ready);
    exp_rd = pop ? (N_CH'(1) << md_gnt) : '0;
    chk("ch_rd_en", ch_rd_en, exp_rd);
    if (!rst_n) begin
      exp_q.delete();
      md_busy = 0; md_ptr = 0; md_beat = 0; md_pkt = 0;
      after_rst = 1;
    end else begin
      if (accept) void'(exp_q.pop_front());
      if (md_busy) begin
        if (pop) begin
          exp_q.push_back(pack(md_beat == 0, md_beat == BL - 1, 8'(md_gnt),
                               {8'(md_gnt), 24'(seq[md_gnt])}));
          md_beat++;
          if (md_beat == BL) begin
            md_busy = 0;
            md_pkt  = (md_pkt + 1) % 65536;
          end
        end
      end else if (en) begin
        for (int k = 0; k < N_CH; k++) begin
          int c;
          c = (md_ptr + k) % N_CH;
          if (ch_burst_rdy[c]) begin
            md_gnt = c; md_ptr = (c + 1) % N_CH; md_busy = 1; md_beat = 0;
            break;
          end
        end
      end
    end
    fifo_pop = ch_rd_en & ch_vld;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_CH; i++) if (fifo_pop[i]) seq[i]++;
    drive_inputs();
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) seq[i] = 0;
    en = 0; ch_burst_rdy = '0; ch_vld = '0; m_ready = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pkt_cnt", pkt_cnt, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_m_sop", m_sop, 0);
    chk("reset_m_eop", m_eop, 0);
    chk("reset_m_ch", m_ch, 0);
    chk("reset_rd_en", ch_rd_en, 0);
    @(posedge clk);
    #1;

    // single channel, full throughput
    rdy_fixed = 4'b0100; drive_inputs();
    repeat (60) step();
    // all channels ready: round robin
    rdy_fixed = 4'b1111;
    repeat (100) step();
    // output backpressure
    p_ready = 50;
    repeat (80) step();
    // source stalls
    p_ready = 100; p_vld = 60;
    repeat (80) step();
    // enable gating
    p_vld = 100; p_en = 0;
    repeat (40) step();
    p_en = 100;
    repeat (40) step();
    // fully random, with one reset pulse in the middle
    rdy_rand = 1; p_vld = 80; p_ready = 70; p_en = 90;
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) rst_pulse = 1;
      step();
    end
    // drain with steady handshakes
    rdy_rand = 0; rdy_fixed = '0; p_vld = 100; p_ready = 100;
    repeat (40) step();
    chk("drained", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
